// File: rtl/decoder_scan_pkg.sv
// rtl/decoder_scan_pkg.sv - shared constants, state encoding and index helpers for decoder_scan
package decoder_pkg;

  localparam int MAX_N    = 8;
  localparam int MAX_OUTS = 1 << MAX_N;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  typedef struct packed {
    logic             found;
    logic             wrapped;
    logic [MAX_N-1:0] idx;
  } next_t;

  // Codes at or beyond 2**n decode to all-zero.
  function automatic logic [MAX_OUTS-1:0] onehot(input logic [MAX_N-1:0] code, input int n);
    logic [MAX_OUTS-1:0] r;
    r = MAX_OUTS'(1) << code;
    if (int'(code) >= (1 << n)) r = '0;
    return r;
  endfunction

  // Next set mask bit strictly above idx, wrapping modulo 2**n; idx itself is the last candidate.
  function automatic next_t next_set(input logic [MAX_OUTS-1:0] mask,
                                     input logic [MAX_N-1:0] idx, input int n);
    next_t r;
    int    outs;
    int    cand;
    r       = '0;
    r.idx   = idx;
    outs    = 1 << n;
    for (int i = 1; i <= MAX_OUTS; i++) begin
      if (!r.found && i <= outs) begin
        cand = (int'(idx) + i) % outs;
        if (mask[MAX_N'(cand)]) begin
          r.found   = 1'b1;
          r.idx     = MAX_N'(cand);
          r.wrapped = (cand <= int'(idx));
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// rtl/decoder_scan_if.sv - control/output bundle for decoder_scan (mask present with DECODER_SCAN_MASK_EN)
interface decoder_scan_if #(
  parameter int N = 3
);
  localparam int OUTS = 1 << N;

  logic            en;
  logic            mode;
  logic [N-1:0]    sel;
  logic            load;
  logic [OUTS-1:0] y;
  logic [N-1:0]    idx;
  logic            valid;
  logic            wrap;
`ifdef DECODER_SCAN_MASK_EN
  logic [OUTS-1:0] mask;

  modport master (output en, mode, sel, load, mask, input y, idx, valid, wrap);
  modport slave  (input en, mode, sel, load, mask, output y, idx, valid, wrap);
`else
  modport master (output en, mode, sel, load, input y, idx, valid, wrap);
  modport slave  (input en, mode, sel, load, output y, idx, valid, wrap);
`endif

endinterface

// File: rtl/decoder_scan_dwell_timer.sv
// rtl/decoder_scan_dwell_timer.sv - dwell counter; tick marks the last cycle of each dwell period
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  // One bit is kept even for DWELL=1 so the compare below stays uniform (count is then always 0).
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot decoder with scan mode; DECODER_SCAN_MASK_EN adds an index mask
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input logic           clk,
  input logic           reset,
  decoder_scan_if.slave bus
);

  localparam int OUTS = 1 << N;

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_HOLD = 2'(HOLD);
  localparam logic [1:0] ST_SCAN = 2'(SCAN);

  logic [1:0]      state_q, state_d;
  logic [OUTS-1:0] y_q, y_d;
  logic [N-1:0]    idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            wrap_q, wrap_d;

  logic            t_clear;
  logic            tick;

  logic [OUTS-1:0]     mask_w;
  logic [MAX_OUTS-1:0] mask_x;
  next_t               step_n;
  next_t               first_n;

`ifdef DECODER_SCAN_MASK_EN
  assign mask_w = bus.mask;
`else
  assign mask_w = '1;
`endif

  assign mask_x = MAX_OUTS'(mask_w);
  assign step_n = next_set(mask_x, MAX_N'(idx_q), N);
  // Searching "above" the top index yields the lowest set bit for scan entry.
  assign first_n = next_set(mask_x, MAX_N'(OUTS - 1), N);

  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (t_clear),
    .run   (!t_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    t_clear = 1'b1;
    if (!bus.en) begin
      state_d = ST_IDLE;
      y_d     = '0;
    end else if (bus.mode == MODE_DECODE) begin
      if (bus.load) begin
        state_d = ST_HOLD;
        idx_d   = bus.sel;
        y_d     = OUTS'(onehot(MAX_N'(bus.sel), N)) & mask_w;
      end else if (state_q == ST_SCAN) begin
        state_d = ST_HOLD;
      end
    end else if (state_q != ST_SCAN) begin
      state_d = ST_SCAN;
      idx_d   = first_n.found ? N'(first_n.idx) : '0;
      y_d     = first_n.found ? OUTS'(onehot(first_n.idx, N)) : '0;
    end else begin
      t_clear = 1'b0;
      if (tick) begin
        // With nothing enabled the output blanks but idx stays put until a bit reappears.
        if (step_n.found) begin
          idx_d  = N'(step_n.idx);
          y_d    = OUTS'(onehot(step_n.idx, N));
          wrap_d = step_n.wrapped;
        end else begin
          y_d = '0;
        end
      end
    end
    valid_d = |y_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised registered N-to-2^N one-hot decoder with an added autonomous scan mode.
- DECODE mode: latches a select code on a load strobe and holds the one-hot output.
- SCAN mode: rotates the one-hot output through all outputs, dwelling DWELL cycles on each. Used for digit/row strobing.
- Successor to the combinational 2-to-4/3-to-8 decoders: the enable is honoured, outputs are registered, and width is generic.

Parameters:
- N, 3, select width; OUTS = 2**N outputs (derived localparam, not overridable).
- DWELL, 4, cycles each output stays active in SCAN mode; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  global enable; 0 forces outputs off.
- mode  input  1  0 = DECODE, 1 = SCAN; sampled every cycle.
- sel  input  N  code to decode in DECODE mode.
- load  input  1  strobe; captures sel in DECODE mode.
- y  output  OUTS  registered one-hot output.
- idx  output  N  index of the currently active output.
- valid  output  1  1 when y is non-zero.
- wrap  output  1  one-cycle pulse when a scan steps from the last active index back to the first.

Behaviour:
- Reset (synchronous, active-high) gives: y=0, idx=0, valid=0, wrap=0, dwell counter=0, state IDLE. Reset overrides all other inputs, including mid-scan.
- States:
  - IDLE: y=0.
  - HOLD: DECODE mode, output latched.
  - SCAN: rotating output.
- Transitions are evaluated every cycle, in this priority order:
  1. en=0 → IDLE next cycle. y=0, valid=0, idx retained, dwell counter cleared.
  2. en=1, mode=0, load=1 → HOLD. Next cycle y = 1<<sel, idx = sel, valid=1. Latency is 1 cycle.
  3. en=1, mode=0, load=0 → state unchanged. HOLD keeps y; IDLE stays IDLE. Coming from SCAN: → HOLD, freezing the current y and idx.
  4. en=1, mode=1, from IDLE or HOLD → SCAN. Next cycle idx=0, y=1, dwell counter=0. load is ignored in SCAN.
  5. In SCAN:
     - The dwell counter increments each cycle.
     - When the counter equals DWELL-1, it clears, and idx advances to (idx+1) mod OUTS on the next edge.
     - With DWELL=1, idx advances every cycle.
- wrap=1 in the same cycle that y becomes the first index after the last one. It is registered alongside y and is otherwise 0.
- Each output stays active for exactly DWELL cycles; a full rotation takes OUTS*DWELL cycles.
- load arriving on the same cycle as en deassert: en wins, so the state goes to IDLE.
- The mode 1→0→1 sequence restarts the scan at idx=0.
- y is always either 0 or exactly one-hot. valid equals the OR-reduction of y, held in a register.

Optional Feature:
- Macro: DECODER_SCAN_MASK_EN.
- When defined, adds port mask (input, OUTS bits).
  - SCAN: skips indices whose mask bit is 0. The next index is the next set bit above idx, wrapping modulo OUTS. wrap fires when that search wraps.
  - Scan entry: starts at the lowest set bit.
  - mask all-zero in SCAN: y=0, valid=0, idx holds, and the counter keeps running.
  - DECODE: a load of a masked sel gives y=0, valid=0, idx=sel.
  - A mask change takes effect at the next advance; it does not cut the current dwell short.
- When undefined: no mask port; all indices are enabled. Behaviour is identical to mask = all ones.

Decomposition:
- Package decoder_pkg:
  - mode constants MODE_DECODE=0, MODE_SCAN=1;
  - state enum {IDLE, HOLD, SCAN};
  - function onehot(code, N) returning OUTS bits;
  - function next_set(mask, idx) for the masked build.
- One sub-module, dwell_timer: parameter DWELL; inputs clk, reset, clear, run; output tick (high when count == DWELL-1). It encapsulates the counter and the DWELL=1 corner case.

Test Plan (N=3, DWELL=2 unless noted):
- Reset then en=1, mode=0, sel=5, load=1 for 1 cycle → next cycle y=8'b0010_0000, idx=5, valid=1; y holds for 10 cycles with load=0.
- en=1, mode=1 from IDLE → y sequence 0x01,0x01,0x02,0x02,…,0x80,0x80,0x01; wrap=1 only on the cycle y returns to 0x01 (cycle 17 after entry).
- DWELL=1: scan advances every cycle; wrap period = 8 cycles; load=1, sel=3 during scan → ignored.
- Mid-scan at y=0x08: drop mode to 0 → y stays 0x08, HOLD; then en=0 → y=0, valid=0, idx=3; load with en=0 → y stays 0.
- Reset asserted mid-scan at y=0x40 → next cycle y=0, idx=0, wrap=0, state IDLE; the scan restarts from 0x01 after reset release.
- DECODER_SCAN_MASK_EN defined, mask=8'b1000_0101 → scan y = 0x01,0x04,0x80,0x01 with wrap on return to 0x01; mask=0 → y=0, valid=0; load sel=1 in DECODE → y=0.
